muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit sitting beside the ALU in the execute stage. It is fed the same rs/rt operands from the register file.
- It owns the HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. The writeback mux consumes hi/lo for MFHI/MFLO.
- The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- start  input  1  launch an operation; sampled when state is IDLE or DONE
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  input  WIDTH  rs operand (multiplicand / dividend)
- b  input  WIDTH  rt operand (multiplier / divisor)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse; HI/LO hold the new result
- div_by_zero  output  1  pulses with done when a DIV/DIVU had b==0
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- On rst_n==0 at a clock edge: state=IDLE, hi=0, lo=0, busy=0, done=0, div_by_zero=0, counter=0, internal datapath=0.
- Reset mid-operation aborts the operation. No partial result reaches hi/lo.

State machine (IDLE, MUL, DIV, DONE):
- IDLE/DONE, start=1: latch op and operand magnitudes.
  - op[1]==0 goes to MUL.
  - op[1]==1 with b!=0 goes to DIV.
  - op[1]==1 with b==0 goes directly to DONE.
- IDLE/DONE, start=0: go to IDLE. DONE always lasts exactly one cycle unless restarted.
- MUL: radix-2 shift-add, one partial product per cycle. After exactly WIDTH cycles, write {hi,lo} and go to DONE.
- DIV: restoring division, one quotient bit per cycle. After exactly WIDTH cycles, write lo=quotient and hi=remainder, then go to DONE.
- start while in MUL or DIV is ignored.

Timing:
- busy=1 exactly when state is MUL or DIV.
- done=1 exactly when state is DONE.
- Latency from the start edge to done=1 is WIDTH+1 cycles (33), or 1 cycle for divide-by-zero.
- hi/lo change only on the edge entering DONE, or on an MTHI/MTLO write.

Signed handling (MULT, DIV):
- Operate on absolute values.
- Negate the product if sign(a)!=sign(b).
- Negate the quotient if sign(a)!=sign(b). The remainder takes the sign of a.
- Unsigned ops use the raw operands.

Arithmetic and boundaries:
- Product is the full 2*WIDTH bits: hi = upper half, lo = lower half.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. The result wraps and no trap is raised.
- Divide by zero: lo=all ones, hi=a unchanged; div_by_zero=1 in the DONE cycle.
- The most-negative operand takes its magnitude as WIDTH-bit unsigned 2^(WIDTH-1).

MTHI/MTLO:
- Honoured only in IDLE or DONE with start=0, taking effect at the next edge.
- hi_we and lo_we may both be asserted in the same cycle.
- Ignored while busy.
- Ignored in the same cycle as an accepted start; the operation result wins.

Operand stability: a and b are needed only in the start cycle. Later changes have no effect.

Decomposition:
- Shared package muldiv_pkg: op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum (IDLE, MUL, DIV, DONE), default WIDTH.
- One sub-module, muldiv_sign, is natural: combinational magnitude extraction and final sign correction, instantiated for input conditioning and result fixup.
- The FSM, counter and shift datapath stay in muldiv_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 32 cycles, then done; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=0x00000007 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9(-7) b=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also DIVU a=100 b=7 -> lo=14, hi=2.
- DIVU a=0x12345678 b=0 -> done on the next cycle with div_by_zero=1, lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- In IDLE, hi_we=1 lo_we=1 wdata=0xA5A5A5A5 -> both registers read 0xA5A5A5A5 next cycle. Start MULTU 3*4, then assert lo_we mid-busy and start again at cycle 10 -> both ignored; result hi=0, lo=12 at cycle 33.
- Start MULT, pull rst_n low at cycle 15 for one edge -> busy=0, done=0, hi=lo=0. A fresh start MULTU 2*3 then yields lo=6 at full latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, FSM state codes and the default operand width.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    // Operation encodings on the op port; op[1] selects divide, op[0] unsigned.
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // FSM state codes.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/muldiv_sign.sv
// Conditional two's-complement negation. Used both to take operand
// magnitudes before iterating and to restore the sign of the results.
// The most-negative value maps onto itself, which read as unsigned is
// exactly its magnitude.
module muldiv_sign #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    // Pass through or negate.
    always_comb begin
        result = negate ? (~value + W'(1)) : value;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// MUL: radix-2 shift-add, DIV: restoring division, one bit per cycle.
// Both run on magnitudes held in a single 2*WIDTH shift register; the sign
// is restored on the edge that writes HI/LO and enters DONE.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    // Upper half: partial product / partial remainder.
    // Lower half: multiplier bits / dividend bits turning into quotient bits.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd_b;     // multiplicand or divisor magnitude
    logic               neg_q;      // product/quotient must be negated
    logic               neg_r;      // remainder must be negated

    logic               is_signed;
    logic               last;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign is_signed = ~op[0];
    assign last      = (cnt == CNT_W'(WIDTH - 1));
    assign busy      = (state == ST_MUL) || (state == ST_DIV);
    assign done      = (state == ST_DONE);

    // Operand conditioning: magnitudes for signed ops, raw values otherwise.
    muldiv_sign #(.W(WIDTH)) u_mag_a (
        .value  (a),
        .negate (is_signed & a[WIDTH-1]),
        .result (mag_a)
    );

    muldiv_sign #(.W(WIDTH)) u_mag_b (
        .value  (b),
        .negate (is_signed & b[WIDTH-1]),
        .result (mag_b)
    );

    // One iteration step for each operation, evaluated from the current acc.
    always_comb begin
        // NOTE: every signal in this block gets a value on every path, so no latch is inferred.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
                  + (acc[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        // The shifted partial remainder is below 2*divisor, so bit WIDTH of
        // the difference is set exactly when the trial subtraction borrows.
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_b};
        div_ok    = ~div_diff[WIDTH];
        div_next  = {(div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc[WIDTH-2:0], div_ok};
    end

    // Result sign fixup, applied to the final step as it is written to HI/LO.
    muldiv_sign #(.W(2*WIDTH)) u_fix_prod (
        .value  (mul_next),
        .negate (neg_q),
        .result (prod_fixed)
    );

    muldiv_sign #(.W(WIDTH)) u_fix_quo (
        .value  (div_next[WIDTH-1:0]),
        .negate (neg_q),
        .result (quo_fixed)
    );

    muldiv_sign #(.W(WIDTH)) u_fix_rem (
        .value  (div_next[2*WIDTH-1:WIDTH]),
        .negate (neg_r),
        .result (rem_fixed)
    );

    // FSM, iteration counter, shift datapath and the HI/LO registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every right-hand side reads pre-edge values.
        if (!rst_n) begin
            // NOTE: the datapath registers are plain flops, not a memory, so they are all cleared here as well.
            state       <= ST_IDLE;
            cnt         <= '0;
            acc         <= '0;
            opnd_b      <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            div_by_zero <= 1'b0;
            case (state)
                ST_MUL, ST_DIV: begin
                    acc <= (state == ST_MUL) ? mul_next : div_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        state <= ST_DONE;
                        if (state == ST_MUL) begin
                            {hi, lo} <= prod_fixed;
                        end else begin
                            lo <= quo_fixed;
                            hi <= rem_fixed;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE: accept a new operation or an MTHI/MTLO write.
                    if (start) begin
                        cnt    <= '0;
                        acc    <= {{WIDTH{1'b0}}, mag_a};
                        opnd_b <= mag_b;
                        neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= is_signed & a[WIDTH-1];
                        if (!op[1]) begin
                            state <= ST_MUL;
                        end else if (b != '0) begin
                            state <= ST_DIV;
                        end else begin
                            state       <= ST_DONE;
                            hi          <= a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end
                    end else begin
                        state <= ST_IDLE;
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit. Expected HI/LO/div_by_zero and
// latency come from a behavioural model and sit in a scoreboard queue
// until the unit raises done.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        logic [7:0]   lat;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    total = 0;
    int    bad = 0;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wdata       (wdata),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    // Behavioural reference: 64-bit arithmetic, truncating division.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t               e;
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] sp;
        logic [63:0]        up;
        sx    = {{32{x[31]}}, x};
        sy    = {{32{y[31]}}, y};
        e.dz  = 1'b0;
        e.lat = 8'd33;
        e.hi  = '0;
        e.lo  = '0;
        case (o)
            OP_MULT: begin
                sp = sx * sy;
                {e.hi, e.lo} = sp;
            end
            OP_MULTU: begin
                up = {32'd0, x} * {32'd0, y};
                {e.hi, e.lo} = up;
            end
            default: begin
                if (y == '0) begin
                    e.hi  = x;
                    e.lo  = '1;
                    e.dz  = 1'b1;
                    e.lat = 8'd1;
                end else if (o == OP_DIV) begin
                    sp   = sx / sy;
                    e.lo = sp[31:0];
                    sp   = sx % sy;
                    e.hi = sp[31:0];
                end else begin
                    e.lo = x / y;
                    e.hi = x % y;
                end
            end
        endcase
        return e;
    endfunction

    // Launch one operation and compare against the scoreboard on done.
    // mode 0: plain; 1: MTHI/MTLO and a restart attempt while busy;
    // 2: MTHI/MTLO together with the start; 3: return in the done cycle.
    // Entered and left just after a falling edge.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input string name, input int mode);
        int    cycles;
        int    busy_n;
        exp_t  e;
        string nm;
        sb_q.push_back(model(o, x, y));
        name_q.push_back(name);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (mode == 2) begin
            hi_we = 1'b1;
            lo_we = 1'b1;
            wdata = 32'hCAFE_F00D;
        end
        cycles = 0;
        busy_n = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                start = 1'b0;
                hi_we = 1'b0;
                lo_we = 1'b0;
                a     = $urandom;
                b     = $urandom;
                op    = 2'($urandom);
            end
            if (busy) busy_n++;
            if (mode == 1) begin
                if (cycles == 5) begin
                    hi_we = 1'b1;
                    lo_we = 1'b1;
                    wdata = 32'hDEAD_BEEF;
                end
                if (cycles == 6) begin
                    hi_we = 1'b0;
                    lo_we = 1'b0;
                end
                if (cycles == 9) begin
                    start = 1'b1;
                    op    = OP_MULT;
                    a     = 32'd9;
                    b     = 32'd9;
                end
                if (cycles == 10) start = 1'b0;
            end
        end while (!done && cycles < 200);

        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s timeout: done not seen after %0d cycles, wanted %0d", nm, cycles, e.lat);
            return;
        end
        if (cycles !== int'(e.lat)) begin
            bad++;
            $display("FAIL %s latency: got %0d want %0d", nm, cycles, e.lat);
        end
        total++;
        if (busy_n !== int'(e.lat) - 1) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d want %0d", nm, busy_n, int'(e.lat) - 1);
        end
        total++;
        if (hi !== e.hi) begin
            bad++;
            $display("FAIL %s hi: got %h want %h", nm, hi, e.hi);
        end
        total++;
        if (lo !== e.lo) begin
            bad++;
            $display("FAIL %s lo: got %h want %h", nm, lo, e.lo);
        end
        total++;
        if (div_by_zero !== e.dz) begin
            bad++;
            $display("FAIL %s div_by_zero: got %b want %b", nm, div_by_zero, e.dz);
        end
        if (mode != 3) begin
            @(negedge clk);
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0) begin
                bad++;
                $display("FAIL %s after_done: got done=%b busy=%b dz=%b want 0 0 0",
                         nm, done, busy, div_by_zero);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, div_by_zero, hi, lo} !== '0) begin
            bad++;
            $display("FAIL reset: got busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
                     busy, done, div_by_zero, hi, lo);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        total++;
        if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL mthi_mtlo_both: got hi=%h lo=%h want a5a5a5a5 a5a5a5a5", hi, lo);
        end
        hi_we = 1'b1;
        wdata = 32'h1111_2222;
        @(negedge clk);
        hi_we = 1'b0;
        total++;
        if (hi !== 32'h1111_2222 || lo !== 32'hA5A5_A5A5) begin
            bad++;
            $display("FAIL mthi_only: got hi=%h lo=%h want 11112222 a5a5a5a5", hi, lo);
        end
    endtask

    task automatic test_mul();
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0);
        run_op(OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, "mult_neg3x7", 0);
        run_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, "mult_minxmin", 0);
        run_op(OP_MULT,  32'h8000_0000, 32'h0000_0001, "mult_minx1", 0);
    endtask

    task automatic test_div();
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0002, "div_neg7by2", 0);
        run_op(OP_DIVU, 32'd100, 32'd7, "divu_100by7", 0);
        run_op(OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, "div_7byneg2", 0);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_neg1", 0);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0001, "divu_max_by1", 0);
    endtask

    task automatic test_div_by_zero();
        run_op(OP_DIVU, 32'h1234_5678, 32'h0, "divu_by_zero", 0);
        run_op(OP_DIV,  32'h8765_4321, 32'h0, "div_by_zero_we", 2);
    endtask

    task automatic test_ignore_while_busy();
        run_op(OP_MULTU, 32'd3, 32'd4, "busy_ignores_we_start", 1);
    endtask

    task automatic test_back_to_back();
        run_op(OP_DIVU, 32'd1000, 32'd33, "b2b_first", 3);
        run_op(OP_MULT, 32'hFFFF_FF00, 32'h0001_0000, "b2b_second", 0);
    endtask

    task automatic test_reset_abort();
        op    = OP_MULT;
        a     = 32'hFFFF_FFFB;
        b     = 32'h0000_0009;
        start = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({busy, done, div_by_zero, hi, lo} !== '0) begin
            bad++;
            $display("FAIL reset_abort: got busy=%b done=%b dz=%b hi=%h lo=%h want all zero",
                     busy, done, div_by_zero, hi, lo);
        end
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (done || busy) break;
        end
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || hi !== '0 || lo !== '0) begin
            bad++;
            $display("FAIL reset_abort_stays_idle: got done=%b busy=%b hi=%h lo=%h want 0 0 0 0",
                     done, busy, hi, lo);
        end
        run_op(OP_MULTU, 32'd2, 32'd3, "after_abort_2x3", 0);
    endtask

    task automatic test_random();
        logic [1:0]   o;
        logic [W-1:0] x;
        logic [W-1:0] y;
        for (int i = 0; i < 8; i++) begin
            o = 2'(i);
            x = $urandom;
            y = (i >= 4) ? ($urandom >> $urandom_range(0, 28)) : $urandom;
            if (y == '0) y = 32'd3;
            run_op(o, x, y, $sformatf("random_%0d", i), 0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_mthi_mtlo();
        test_mul();
        test_div();
        test_div_by_zero();
        test_ignore_while_busy();
        test_back_to_back();
        test_reset_abort();
        test_random();
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
